// File: rtl/activate_diff_pipe_reg_pkg.sv
// Shared payload definition for the activate->diff pipeline register.
// The packed struct fixes field order; pack/unpack convert it to and from a flat slot word.
package act_pipe_pkg;

  localparam int SIZE            = 3;
  localparam int DATA_SIZE       = 16;
  localparam int COST_TYPE_SIZE  = 8;
  localparam int DENSE_TYPE_SIZE = 4;
  localparam int VEC_W           = SIZE * DATA_SIZE;

  typedef struct packed {
    logic [VEC_W-1:0]           label;
    logic [COST_TYPE_SIZE-1:0]  cost_type;
    logic [DENSE_TYPE_SIZE-1:0] dense_type;
    logic                       backprop_cost;
    logic [VEC_W-1:0]           w;
    logic [VEC_W-1:0]           x;
    logic [31:0]                w_layer_index;
    logic [31:0]                w_row_index;
    logic                       is_update;
    logic [VEC_W-1:0]           z;
  } act_diff_payload_t;

  localparam int ACT_DIFF_PAYLOAD_W = $bits(act_diff_payload_t);

  function automatic logic [ACT_DIFF_PAYLOAD_W-1:0] pack_payload(input act_diff_payload_t p);
    return p;
  endfunction

  function automatic act_diff_payload_t unpack_payload(input logic [ACT_DIFF_PAYLOAD_W-1:0] b);
    return b;
  endfunction

endpackage

// File: rtl/activate_diff_pipe_reg_if.sv
// Valid/ready bundle between the activation stage and the diff stage, including
// flush and occupancy; master is the surrounding logic, slave is the pipe register.
interface activate_diff_pipe_reg_if #(parameter int depth = 2);
  import act_pipe_pkg::*;

  localparam int CW = $clog2(depth + 1);

  logic                       flush;
  logic                       in_valid;
  logic                       in_ready;
  logic [VEC_W-1:0]           label;
  logic [COST_TYPE_SIZE-1:0]  cost_type;
  logic [DENSE_TYPE_SIZE-1:0] dense_type;
  logic                       backprop_cost;
  logic [VEC_W-1:0]           w;
  logic [VEC_W-1:0]           x;
  logic [31:0]                w_layer_index;
  logic [31:0]                w_row_index;
  logic                       is_update;
  logic [VEC_W-1:0]           z;

  logic                       out_valid;
  logic                       out_ready;
  logic [VEC_W-1:0]           label_out;
  logic [COST_TYPE_SIZE-1:0]  cost_type_out;
  logic [DENSE_TYPE_SIZE-1:0] dense_type_out;
  logic                       backprop_cost_out;
  logic [VEC_W-1:0]           w_out;
  logic [VEC_W-1:0]           x_out;
  logic [31:0]                w_layer_index_out;
  logic [31:0]                w_row_index_out;
  logic                       is_update_out;
  logic [VEC_W-1:0]           z_out;
  logic [CW-1:0]              count;

  modport master (
    output flush, in_valid, label, cost_type, dense_type, backprop_cost, w, x,
           w_layer_index, w_row_index, is_update, z, out_ready,
    input  in_ready, out_valid, label_out, cost_type_out, dense_type_out, backprop_cost_out,
           w_out, x_out, w_layer_index_out, w_row_index_out, is_update_out, z_out, count
  );

  modport slave (
    input  flush, in_valid, label, cost_type, dense_type, backprop_cost, w, x,
           w_layer_index, w_row_index, is_update, z, out_ready,
    output in_ready, out_valid, label_out, cost_type_out, dense_type_out, backprop_cost_out,
           w_out, x_out, w_layer_index_out, w_row_index_out, is_update_out, z_out, count
  );

endinterface

// File: rtl/activate_diff_pipe_reg_elastic_slot.sv
// One stage of the elastic pipe: a valid bit plus a payload register that
// only changes on a transfer into the slot.
module elastic_slot #(parameter int W = 8) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         load,
  input  logic [W-1:0] d,
  input  logic         clear_valid,
  output logic [W-1:0] q,
  output logic         valid
);

  // Flush only drops the valid bit; stale payload is harmless once invalid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else begin
      if (load) q <= d;
      valid <= load | (valid & ~clear_valid);
    end
  end

endmodule

// File: rtl/activate_diff_pipe_reg.sv
// Elastic DEPTH-slot valid/ready register for the activate->diff bundle with
// bubble collapse, flush and occupancy count.
module activate_diff_pipe_reg
  import act_pipe_pkg::*;
#(
  parameter int depth = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  activate_diff_pipe_reg_if.slave   bus
);

  localparam int PW = ACT_DIFF_PAYLOAD_W;
  localparam int CW = $clog2(depth + 1);

  act_diff_payload_t in_pl;
  act_diff_payload_t out_pl;
  logic [PW-1:0]     slot_q [depth];
  logic [depth-1:0]  v;
  logic [depth-1:0]  adv;
  logic [depth-1:0]  load;
  logic              in_ready;
  logic              in_xfer;
  logic              out_xfer;
  logic [CW-1:0]     count;

  always_comb begin
    in_pl               = '0;
    in_pl.label         = bus.label;
    in_pl.cost_type     = bus.cost_type;
    in_pl.dense_type    = bus.dense_type;
    in_pl.backprop_cost = bus.backprop_cost;
    in_pl.w             = bus.w;
    in_pl.x             = bus.x;
    in_pl.w_layer_index = bus.w_layer_index;
    in_pl.w_row_index   = bus.w_row_index;
    in_pl.is_update     = bus.is_update;
    in_pl.z             = bus.z;
  end

  // Advance chain runs from the output back to slot 0 so a free slot anywhere
  // ahead lets everything behind it move up; flush freezes the whole chain.
  always_comb begin
    adv          = '0;
    adv[depth-1] = v[depth-1] & bus.out_ready & ~bus.flush;
    for (int k = depth - 2; k >= 0; k--) begin
      adv[k] = v[k] & (~v[k+1] | adv[k+1]) & ~bus.flush;
    end
  end

  assign in_ready = ~bus.flush & (~v[0] | adv[0]);
  assign in_xfer  = bus.in_valid & in_ready;
  assign out_xfer = adv[depth-1];

  always_comb begin
    load    = '0;
    load[0] = in_xfer;
    for (int k = 1; k < depth; k++) begin
      load[k] = adv[k-1];
    end
  end

  for (genvar k = 0; k < depth; k++) begin : g_slot
    logic [PW-1:0] d;
    if (k == 0) begin : g_head
      assign d = pack_payload(in_pl);
    end else begin : g_tail
      assign d = slot_q[k-1];
    end

    elastic_slot #(.W(PW)) u_slot (
      .clk         (clk),
      .rst         (rst),
      .flush       (bus.flush),
      .load        (load[k]),
      .d           (d),
      .clear_valid (adv[k]),
      .q           (slot_q[k]),
      .valid       (v[k])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (bus.flush) begin
      count <= '0;
    end else if (in_xfer && !out_xfer) begin
      count <= count + CW'(1);
    end else if (!in_xfer && out_xfer) begin
      count <= count - CW'(1);
    end
  end

  assign out_pl = unpack_payload(slot_q[depth-1]);

  assign bus.in_ready          = in_ready;
  assign bus.out_valid         = v[depth-1];
  assign bus.count             = count;
  assign bus.label_out         = out_pl.label;
  assign bus.cost_type_out     = out_pl.cost_type;
  assign bus.dense_type_out    = out_pl.dense_type;
  assign bus.backprop_cost_out = out_pl.backprop_cost;
  assign bus.w_out             = out_pl.w;
  assign bus.x_out             = out_pl.x;
  assign bus.w_layer_index_out = out_pl.w_layer_index;
  assign bus.w_row_index_out   = out_pl.w_row_index;
  assign bus.is_update_out     = out_pl.is_update;
  assign bus.z_out             = out_pl.z;

endmodule

// File: tb/tb_activate_diff_pipe_reg.sv
// Bench for activate_diff_pipe_reg: four depths share one stimulus stream, each
// watched every cycle by a queue-based reference, plus directed corner sequences.
module tb_activate_diff_pipe_reg;
  import act_pipe_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              out_ready;
  act_diff_payload_t drv;

  logic              mon_ready [4];
  logic              mon_valid [4];
  logic [31:0]       mon_count [4];
  act_diff_payload_t mon_out   [4];

  int tests = 0;
  int fails = 0;
  int cycle = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int D = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 : 5;
    activate_diff_pipe_reg_if #(.depth(D)) bus ();
    act_diff_payload_t o;

    activate_diff_pipe_reg #(.depth(D)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );

    assign bus.flush         = flush;
    assign bus.in_valid      = in_valid;
    assign bus.out_ready     = out_ready;
    assign bus.label         = drv.label;
    assign bus.cost_type     = drv.cost_type;
    assign bus.dense_type    = drv.dense_type;
    assign bus.backprop_cost = drv.backprop_cost;
    assign bus.w             = drv.w;
    assign bus.x             = drv.x;
    assign bus.w_layer_index = drv.w_layer_index;
    assign bus.w_row_index   = drv.w_row_index;
    assign bus.is_update     = drv.is_update;
    assign bus.z             = drv.z;

    assign o.label         = bus.label_out;
    assign o.cost_type     = bus.cost_type_out;
    assign o.dense_type    = bus.dense_type_out;
    assign o.backprop_cost = bus.backprop_cost_out;
    assign o.w             = bus.w_out;
    assign o.x             = bus.x_out;
    assign o.w_layer_index = bus.w_layer_index_out;
    assign o.w_row_index   = bus.w_row_index_out;
    assign o.is_update     = bus.is_update_out;
    assign o.z             = bus.z_out;

    assign mon_ready[g] = bus.in_ready;
    assign mon_valid[g] = bus.out_valid;
    assign mon_count[g] = 32'(bus.count);
    assign mon_out[g]   = o;
  end

  function automatic int dep(input int g);
    case (g)
      0:       return 1;
      1:       return 2;
      2:       return 4;
      default: return 5;
    endcase
  endfunction

  function automatic act_diff_payload_t rand_pl(input int tag);
    act_diff_payload_t p;
    p = '0;
    for (int i = 0; i < SIZE; i++) begin
      p.label[i*DATA_SIZE +: DATA_SIZE] = DATA_SIZE'($urandom);
      p.w[i*DATA_SIZE +: DATA_SIZE]     = DATA_SIZE'($urandom);
      p.x[i*DATA_SIZE +: DATA_SIZE]     = DATA_SIZE'($urandom);
      p.z[i*DATA_SIZE +: DATA_SIZE]     = DATA_SIZE'($urandom);
    end
    p.cost_type     = COST_TYPE_SIZE'($urandom);
    p.dense_type    = DENSE_TYPE_SIZE'($urandom);
    p.backprop_cost = 1'($urandom);
    p.w_layer_index = $urandom;
    p.w_row_index   = tag;
    p.is_update     = 1'($urandom);
    return p;
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic check_wide(input string name, input act_diff_payload_t actual, input act_diff_payload_t expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input logic iv, input logic orr, input logic fl, input act_diff_payload_t p);
    @(negedge clk);
    in_valid  = iv;
    out_ready = orr;
    flush     = fl;
    drv       = p;
    #1;
  endtask

  task automatic clear_all();
    apply_stimulus(1'b0, 1'b0, 1'b1, '0);
    apply_stimulus(1'b0, 1'b0, 1'b0, '0);
  endtask

  // Reference: an ordered queue per depth. An entry reaches the output once it is
  // the oldest and depth edges have passed since acceptance; capacity is depth.
  act_diff_payload_t mq [4][8];
  int                mc [4][8];
  int                mhead [4];
  int                msize [4];

  always begin
    @(negedge clk);
    #4;
    for (int g = 0; g < 4; g++) begin
      int   d;
      int   idx;
      logic exp_ready;
      logic exp_valid;
      d = dep(g);
      if (rst) begin
        msize[g] = 0;
        mhead[g] = 0;
        check_output($sformatf("d%0d_rst_out_valid", d), 32'(mon_valid[g]), 0);
        check_output($sformatf("d%0d_rst_count", d), mon_count[g], 0);
        check_wide($sformatf("d%0d_rst_payload", d), mon_out[g], '0);
      end else begin
        exp_ready = !flush && (msize[g] < d || out_ready);
        exp_valid = msize[g] > 0 && (cycle - mc[g][mhead[g]]) >= d;
        check_output($sformatf("d%0d_in_ready", d), 32'(mon_ready[g]), 32'(exp_ready));
        check_output($sformatf("d%0d_out_valid", d), 32'(mon_valid[g]), 32'(exp_valid));
        check_output($sformatf("d%0d_count", d), mon_count[g], 32'(msize[g]));
        if (exp_valid) check_wide($sformatf("d%0d_payload", d), mon_out[g], mq[g][mhead[g]]);
        if (flush) begin
          msize[g] = 0;
        end else begin
          if (exp_valid && out_ready) begin
            mhead[g] = (mhead[g] + 1) % 8;
            msize[g] = msize[g] - 1;
          end
          if (in_valid && exp_ready) begin
            idx         = (mhead[g] + msize[g]) % 8;
            mq[g][idx]  = drv;
            mc[g][idx]  = cycle;
            msize[g]    = msize[g] + 1;
          end
        end
      end
    end
  end

  typedef struct {
    logic iv;
    logic orr;
    logic fl;
    int   tag;
    logic exp_ready;
    logic exp_valid;
    int   exp_count;
    int   exp_row;
  } vec_t;

  initial begin
    vec_t              tab [9];
    act_diff_payload_t tp  [3];
    act_diff_payload_t seq [4];
    act_diff_payload_t p;
    int                acc;
    int                del;

    tab[0] = '{1'b1, 1'b0, 1'b0, 100, 1'b1, 1'b0, 0, -1};
    tab[1] = '{1'b1, 1'b0, 1'b0, 101, 1'b1, 1'b0, 1, -1};
    tab[2] = '{1'b1, 1'b0, 1'b0, 102, 1'b0, 1'b1, 2, 100};
    tab[3] = '{1'b1, 1'b0, 1'b0, 102, 1'b0, 1'b1, 2, 100};
    tab[4] = '{1'b1, 1'b1, 1'b0, 102, 1'b1, 1'b1, 2, 100};
    tab[5] = '{1'b0, 1'b0, 1'b0, 0,   1'b0, 1'b1, 2, 101};
    tab[6] = '{1'b0, 1'b1, 1'b0, 0,   1'b1, 1'b1, 2, 101};
    tab[7] = '{1'b0, 1'b1, 1'b0, 0,   1'b1, 1'b1, 1, 102};
    tab[8] = '{1'b0, 1'b0, 1'b0, 0,   1'b1, 1'b0, 0, -1};
    for (int i = 0; i < 3; i++) tp[i] = rand_pl(100 + i);

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; drv = '0;
    repeat (3) @(negedge clk);
    #1;
    check_output("reset_out_valid", 32'(mon_valid[1]), 0);
    check_output("reset_count", mon_count[1], 0);
    check_wide("reset_payload", mon_out[1], '0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_output("release_in_ready", 32'(mon_ready[1]), 1);

    // Reset with two entries in flight.
    apply_stimulus(1'b1, 1'b0, 1'b0, rand_pl(50));
    apply_stimulus(1'b1, 1'b0, 1'b0, rand_pl(51));
    apply_stimulus(1'b0, 1'b0, 1'b0, '0);
    check_output("pre_rst_count", mon_count[1], 2);
    rst = 1'b1;
    #1;
    check_output("mid_rst_out_valid", 32'(mon_valid[1]), 0);
    check_output("mid_rst_count", mon_count[1], 0);
    check_wide("mid_rst_payload", mon_out[1], '0);
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back streaming through depth 2.
    for (int j = 0; j <= 10; j++) begin
      p = (j < 8) ? rand_pl(j) : '0;
      apply_stimulus(j < 8, 1'b1, 1'b0, p);
      acc = (j < 8) ? j : 8;
      del = (j > 2) ? ((j - 2 < 8) ? j - 2 : 8) : 0;
      if (j < 8) check_output($sformatf("stream_in_ready_%0d", j), 32'(mon_ready[1]), 1);
      check_output($sformatf("stream_out_valid_%0d", j), 32'(mon_valid[1]), 32'(j >= 2 && j < 10));
      check_output($sformatf("stream_count_%0d", j), mon_count[1], 32'(acc - del));
      if (j >= 2 && j < 10) check_output($sformatf("stream_row_%0d", j), mon_out[1].w_row_index, 32'(j - 2));
    end

    // Backpressure table on depth 2.
    clear_all();
    for (int i = 0; i < 9; i++) begin
      p = (tab[i].tag >= 100) ? tp[tab[i].tag - 100] : '0;
      apply_stimulus(tab[i].iv, tab[i].orr, tab[i].fl, p);
      check_output($sformatf("bp_in_ready_%0d", i), 32'(mon_ready[1]), 32'(tab[i].exp_ready));
      check_output($sformatf("bp_out_valid_%0d", i), 32'(mon_valid[1]), 32'(tab[i].exp_valid));
      check_output($sformatf("bp_count_%0d", i), mon_count[1], 32'(tab[i].exp_count));
      if (tab[i].exp_row >= 100) check_wide($sformatf("bp_payload_%0d", i), mon_out[1], tp[tab[i].exp_row - 100]);
    end

    // Bubble collapse on depth 4.
    clear_all();
    seq[0]   = rand_pl(200);
    seq[0].z = {SIZE{16'h1234}};
    for (int i = 1; i < 4; i++) seq[i] = rand_pl(200 + i);
    apply_stimulus(1'b1, 1'b0, 1'b0, seq[0]);
    repeat (3) apply_stimulus(1'b0, 1'b0, 1'b0, '0);
    apply_stimulus(1'b1, 1'b0, 1'b0, seq[1]);
    check_output("bubble_head_valid", 32'(mon_valid[2]), 1);
    check_wide("bubble_head_payload", mon_out[2], seq[0]);
    check_output("bubble_accept_1", 32'(mon_ready[2]), 1);
    apply_stimulus(1'b1, 1'b0, 1'b0, seq[2]);
    check_output("bubble_accept_2", 32'(mon_ready[2]), 1);
    apply_stimulus(1'b1, 1'b0, 1'b0, seq[3]);
    check_output("bubble_accept_3", 32'(mon_ready[2]), 1);
    apply_stimulus(1'b1, 1'b0, 1'b0, rand_pl(299));
    check_output("bubble_full_count", mon_count[2], 4);
    check_output("bubble_full_in_ready", 32'(mon_ready[2]), 0);
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1'b0, 1'b1, 1'b0, '0);
      check_output($sformatf("bubble_drain_valid_%0d", i), 32'(mon_valid[2]), 1);
      check_wide($sformatf("bubble_drain_payload_%0d", i), mon_out[2], seq[i]);
    end
    apply_stimulus(1'b0, 1'b0, 1'b0, '0);
    check_output("bubble_empty_count", mon_count[2], 0);

    // Flush with in_valid and out_ready both asserted, depth 4.
    clear_all();
    for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 1'b0, 1'b0, rand_pl(300 + i));
    apply_stimulus(1'b1, 1'b1, 1'b1, rand_pl(303));
    check_output("flush_pre_count", mon_count[2], 3);
    check_output("flush_in_ready", 32'(mon_ready[2]), 0);
    apply_stimulus(1'b0, 1'b0, 1'b0, '0);
    check_output("flush_post_count", mon_count[2], 0);
    check_output("flush_post_out_valid", 32'(mon_valid[2]), 0);
    check_output("flush_post_in_ready", 32'(mon_ready[2]), 1);

    // Random traffic with occasional flush and reset pulses.
    for (int i = 0; i < 10000; i++) begin
      apply_stimulus($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6,
                     $urandom_range(0, 199) == 0, rand_pl(1000 + i));
      rst = ($urandom_range(0, 1499) == 0);
    end
    apply_stimulus(1'b0, 1'b0, 1'b0, '0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
